// File: rtl/uart_cmd_handler_if.sv
// uart_cmd_handler_if: UART word handshake plus memory request bus.
// master = command handler, slave = UART and memory side.
interface uart_cmd_handler_if;
    logic        uart_read;
    logic        uart_write;
    logic        uart_response;
    logic [31:0] uart_read_data;
    logic [31:0] uart_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output uart_read, uart_write, uart_write_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  uart_response, uart_read_data, mem_rdata, mem_ack
    );

    modport slave (
        input  uart_read, uart_write, uart_write_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output uart_response, uart_read_data, mem_rdata, mem_ack
    );
endinterface

// File: rtl/uart_cmd_handler.sv
// uart_cmd_handler: pulls command/argument words from the UART, runs
// PING / READ_MEM / WRITE_MEM / CORE_RST and returns one reply word.
// Ports: clk, reset (sync, active high), bus (UART + memory, master),
//   core_reset (level, holds the core), cmd_error (one-cycle pulse).
// Optional: define CMD_TIMEOUT_EN to abort a command whose arguments
//   do not arrive within TIMEOUT_CYCLES clocks.
module uart_cmd_handler #(
    parameter logic [31:0] PONG_WORD = 32'h706F6E67,
    parameter logic [31:0] ACK_WORD  = 32'h00000001,
    parameter logic [31:0] ERR_WORD  = 32'hFFFFFFFF
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 25000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    uart_cmd_handler_if.master bus,
    output logic               core_reset,
    output logic               cmd_error
);
    localparam logic [7:0] OP_PING  = 8'h70;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_CRST  = 8'h43;

    typedef enum logic [2:0] {
        IDLE, WAIT_CMD, DECODE, WAIT_ADDR,
        WAIT_DATA, MEM, SEND, WAIT_TX
    } state_t;

    state_t      state, state_nxt;
    // Only the opcode byte and the core-reset bit of a command matter.
    logic [8:0]  cmd, cmd_nxt;
    logic [31:0] rdata, rdata_nxt;
    logic [31:0] reply;
    logic        read_nxt, write_nxt, req_nxt, we_nxt;
    logic        core_nxt, err_nxt;
    logic [31:0] tx_nxt, addr_nxt, wdata_nxt;
    logic        timeout;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] timer;

    assign timeout = (timer == TIMEOUT_CYCLES - 1);

    // Counts argument-wait cycles; any state change restarts it.
    always_ff @(posedge clk) begin
        if (reset || state_nxt != state)
            timer <= '0;
        else if (state == WAIT_ADDR || state == WAIT_DATA)
            timer <= timer + 32'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        reply = ERR_WORD;
        case (cmd[7:0])
            OP_PING:           reply = PONG_WORD;
            OP_READ:           reply = rdata;
            OP_WRITE, OP_CRST: reply = ACK_WORD;
            default:           reply = ERR_WORD;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        rdata_nxt = rdata;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        err_nxt   = 1'b0;
        tx_nxt    = bus.uart_write_data;
        req_nxt   = bus.mem_req;
        we_nxt    = bus.mem_we;
        addr_nxt  = bus.mem_addr;
        wdata_nxt = bus.mem_wdata;
        core_nxt  = core_reset;
        unique case (state)
            IDLE: begin
                read_nxt  = 1'b1;
                state_nxt = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (bus.uart_response) begin
                    cmd_nxt   = bus.uart_read_data[8:0];
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = SEND;
                case (cmd[7:0])
                    OP_READ, OP_WRITE: begin
                        read_nxt  = 1'b1;
                        we_nxt    = (cmd[7:0] == OP_WRITE);
                        state_nxt = WAIT_ADDR;
                    end
                    OP_CRST: core_nxt = cmd[8];
                    OP_PING: ;
                    default: err_nxt = 1'b1;
                endcase
            end
            WAIT_ADDR: begin
                if (bus.uart_response) begin
                    addr_nxt = bus.uart_read_data;
                    if (bus.mem_we) begin
                        read_nxt  = 1'b1;
                        state_nxt = WAIT_DATA;
                    end else begin
                        req_nxt   = 1'b1;
                        state_nxt = MEM;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                if (bus.uart_response) begin
                    wdata_nxt = bus.uart_read_data;
                    req_nxt   = 1'b1;
                    state_nxt = MEM;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    rdata_nxt = bus.mem_rdata;
                    req_nxt   = 1'b0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_nxt    = reply;
                write_nxt = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.uart_response)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cmd                 <= '0;
            rdata               <= '0;
            bus.uart_read       <= 1'b0;
            bus.uart_write      <= 1'b0;
            bus.uart_write_data <= '0;
            bus.mem_req         <= 1'b0;
            bus.mem_we          <= 1'b0;
            bus.mem_addr        <= '0;
            bus.mem_wdata       <= '0;
            core_reset          <= 1'b1;
            cmd_error           <= 1'b0;
        end else begin
            state               <= state_nxt;
            cmd                 <= cmd_nxt;
            rdata               <= rdata_nxt;
            bus.uart_read       <= read_nxt;
            bus.uart_write      <= write_nxt;
            bus.uart_write_data <= tx_nxt;
            bus.mem_req         <= req_nxt;
            bus.mem_we          <= we_nxt;
            bus.mem_addr        <= addr_nxt;
            bus.mem_wdata       <= wdata_nxt;
            core_reset          <= core_nxt;
            cmd_error           <= err_nxt;
        end
    end
endmodule

// File: tb/tb_uart_cmd_handler.sv
// tb_uart_cmd_handler: acts as UART and memory, compares every reply,
// memory access, error pulse and core_reset level against a command model.
module tb_uart_cmd_handler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic core_reset;
    logic cmd_error;

    uart_cmd_handler_if bus ();

    uart_cmd_handler dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .core_reset(core_reset),
        .cmd_error (cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int reads_pending = 0;
    int writes_pending = 0;
    int overlap = 0;
    int err_pulses = 0;
    logic [31:0] tx_word;
    int resp_max = 3;
    int last_resp_cyc;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          req_cyc;
        logic        req_after;
        logic        stable;
    } mem_txn_t;

    mem_txn_t mem_log[$];
    logic [31:0] phys[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic model_core = 1'b1;
    bit mem_auto = 1'b1;
    int mem_lat = -1;
    bit inject_ack = 1'b0;

    // Contents of never-written memory locations.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.uart_read === 1'b1) reads_pending++;
        if (bus.uart_write === 1'b1) begin
            writes_pending++;
            tx_word = bus.uart_write_data;
        end
        if (bus.uart_read === 1'b1 && bus.uart_write === 1'b1) overlap++;
        if (cmd_error === 1'b1) err_pulses++;
    end

    // Memory responder.
    initial begin
        mem_txn_t t;
        int lat;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (inject_ack) begin
                inject_ack = 1'b0;
                bus.mem_rdata = $urandom;
                bus.mem_ack = 1'b1;
                @(negedge clk);
                #1;
                bus.mem_ack = 1'b0;
            end else if (mem_auto && bus.mem_req === 1'b1) begin
                t.we = bus.mem_we;
                t.addr = bus.mem_addr;
                t.wdata = bus.mem_wdata;
                t.req_cyc = cyc;
                lat = (mem_lat < 0) ? $urandom_range(0, 3) : mem_lat;
                if (lat > 0) begin
                    repeat (lat) @(negedge clk);
                    #1;
                end
                t.stable = (bus.mem_req === 1'b1) && (bus.mem_we === t.we)
                    && (bus.mem_addr === t.addr) && (bus.mem_wdata === t.wdata);
                if (t.we) phys[t.addr] = t.wdata;
                if (t.we) bus.mem_rdata = $urandom;
                else if (phys.exists(t.addr)) bus.mem_rdata = phys[t.addr];
                else bus.mem_rdata = pattern(t.addr);
                bus.mem_ack = 1'b1;
                @(negedge clk);
                #1;
                bus.mem_ack = 1'b0;
                t.req_after = bus.mem_req;
                mem_log.push_back(t);
            end
        end
    end

    task automatic feed_word(input logic [31:0] w, input string name, output bit ok);
        int d;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (reads_pending > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s read_wait: got no uart_read want a pulse", name);
            return;
        end
        reads_pending--;
        d = $urandom_range(0, resp_max);
        repeat (d) @(negedge clk);
        bus.uart_read_data = w;
        bus.uart_response = 1'b1;
        last_resp_cyc = cyc + 1;
        @(negedge clk);
        bus.uart_response = 1'b0;
        bus.uart_read_data = $urandom;
    endtask

    task automatic run_cmd(input string name, input logic [31:0] w0, w1, w2,
                           input bit stray, input int gap);
        int nargs;
        bit exp_mem;
        bit exp_we;
        int exp_err;
        bit ok;
        bit stray_done;
        logic [31:0] exp_reply;
        logic [31:0] words[3];
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        nargs = 0;
        exp_mem = 1'b0;
        exp_we = 1'b0;
        exp_err = 0;
        case (w0[7:0])
            8'h70: exp_reply = 32'h706F6E67;
            8'h52: begin
                nargs = 1;
                exp_mem = 1'b1;
                exp_reply = model_mem.exists(w1) ? model_mem[w1] : pattern(w1);
            end
            8'h57: begin
                nargs = 2;
                exp_mem = 1'b1;
                exp_we = 1'b1;
                exp_reply = 32'h1;
                model_mem[w1] = w2;
            end
            8'h43: begin
                model_core = w0[8];
                exp_reply = 32'h1;
            end
            default: begin
                exp_err = 1;
                exp_reply = 32'hFFFF_FFFF;
            end
        endcase
        mem_log.delete();
        err_pulses = 0;
        for (int i = 0; i <= nargs; i++) begin
            if (i == 1 && gap > 0) repeat (gap) @(negedge clk);
            feed_word(words[i], name, ok);
            if (!ok) return;
        end
        ok = 1'b0;
        stray_done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (stray && !stray_done && bus.mem_req === 1'b1) begin
                stray_done = 1'b1;
                bus.uart_read_data = $urandom;
                bus.uart_response = 1'b1;
                @(negedge clk);
                #1;
                bus.uart_response = 1'b0;
            end
            if (writes_pending > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s write_wait: got no uart_write want a pulse", name);
            return;
        end
        writes_pending--;
        checks++;
        if (tx_word !== exp_reply) begin
            errors++;
            $display("FAIL %s reply: got %h want %h", name, tx_word, exp_reply);
        end
        checks++;
        if (reads_pending !== 0) begin
            errors++;
            $display("FAIL %s extra_read: got %0d want 0", name, reads_pending);
        end
        repeat ($urandom_range(0, resp_max)) @(negedge clk);
        #1;
        checks++;
        if (bus.uart_write_data !== tx_word) begin
            errors++;
            $display("FAIL %s tx_hold: got %h want %h", name, bus.uart_write_data, tx_word);
        end
        bus.uart_response = 1'b1;
        @(negedge clk);
        bus.uart_response = 1'b0;
        checks++;
        if (mem_log.size() !== (exp_mem ? 1 : 0)) begin
            errors++;
            $display("FAIL %s mem_count: got %0d want %0d", name, mem_log.size(), exp_mem);
        end else if (exp_mem) begin
            checks++;
            if (mem_log[0].we !== exp_we || mem_log[0].addr !== w1) begin
                errors++;
                $display("FAIL %s mem_cmd: got we=%b addr=%h want we=%b addr=%h",
                         name, mem_log[0].we, mem_log[0].addr, exp_we, w1);
            end
            if (exp_we) begin
                checks++;
                if (mem_log[0].wdata !== w2) begin
                    errors++;
                    $display("FAIL %s mem_wdata: got %h want %h", name, mem_log[0].wdata, w2);
                end
            end
            checks++;
            if (mem_log[0].req_cyc !== last_resp_cyc) begin
                errors++;
                $display("FAIL %s req_latency: got cycle %0d want %0d",
                         name, mem_log[0].req_cyc, last_resp_cyc);
            end
            checks++;
            if (mem_log[0].req_after !== 1'b0 || mem_log[0].stable !== 1'b1) begin
                errors++;
                $display("FAIL %s req_shape: got after=%b stable=%b want 0 1",
                         name, mem_log[0].req_after, mem_log[0].stable);
            end
        end
        checks++;
        if (err_pulses !== exp_err) begin
            errors++;
            $display("FAIL %s cmd_error: got %0d want %0d", name, err_pulses, exp_err);
        end
        checks++;
        if (core_reset !== model_core) begin
            errors++;
            $display("FAIL %s core_reset: got %b want %b", name, core_reset, model_core);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.uart_read !== 1'b0 || bus.uart_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_uart: got rd=%b wr=%b want 0 0", bus.uart_read, bus.uart_write);
        end
        checks++;
        if (bus.uart_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_txdata: got %h want 0", bus.uart_write_data);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: got req=%b we=%b want 0 0", bus.mem_req, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (core_reset !== 1'b1 || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got core=%b err=%b want 1 0", core_reset, cmd_error);
        end
        reads_pending = 0;
        writes_pending = 0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.uart_read !== 1'b1) begin
            errors++;
            $display("FAIL first_read: got %b want 1", bus.uart_read);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.uart_read !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse_width: got %b want 0", bus.uart_read);
        end
    endtask

    task automatic test_ping;
        run_cmd("ping", 32'h0000_0070, 32'h0, 32'h0, 1'b0, 0);
    endtask

    task automatic test_write_mem;
        mem_lat = 3;
        run_cmd("write_mem", 32'h0000_0057, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0);
        mem_lat = -1;
    endtask

    task automatic test_read_mem;
        phys[32'h100] = 32'hCAFE_F00D;
        model_mem[32'h100] = 32'hCAFE_F00D;
        run_cmd("read_mem", 32'h0000_0052, 32'h0000_0100, 32'h0, 1'b0, 0);
    endtask

    task automatic test_core_rst_error;
        run_cmd("core_rst_clr", 32'h0000_0043, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("bad_opcode", 32'h0000_00AA, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("core_rst_set", 32'h0000_0143, 32'h0, 32'h0, 1'b0, 0);
    endtask

    task automatic test_arg_wait;
        run_cmd("slow_arg", 32'h0000_0052, 32'h0000_0104, 32'h0, 1'b0, 300);
    endtask

    task automatic test_random;
        logic [31:0] hi;
        logic [31:0] a;
        logic [7:0] op;
        int r;
        for (int n = 0; n < 40; n++) begin
            hi = $urandom;
            a = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            r = $urandom_range(0, 5);
            case (r)
                0: op = 8'h70;
                1: op = 8'h52;
                2, 3: op = 8'h57;
                4: op = 8'h43;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h70 || op == 8'h52 || op == 8'h57 || op == 8'h43)
                        op = 8'($urandom_range(0, 255));
                end
            endcase
            run_cmd("random", {hi[31:8], op}, a, $urandom, 1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_back_to_back;
        mem_lat = 0;
        resp_max = 0;
        run_cmd("b2b_w", 32'h57, 32'h300, 32'h1234_5678, 1'b0, 0);
        run_cmd("b2b_r", 32'h52, 32'h300, 32'h0, 1'b0, 0);
        run_cmd("b2b_p", 32'h70, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("b2b_c", 32'h43, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("b2b_e", 32'h00, 32'h0, 32'h0, 1'b0, 0);
        run_cmd("b2b_r2", 32'h52, 32'h304, 32'h0, 1'b0, 0);
        mem_lat = -1;
        resp_max = 3;
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL rd_wr_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    task automatic test_reset_mid_mem;
        bit ok;
        mem_auto = 1'b0;
        feed_word(32'h52, "mid_reset", ok);
        if (ok) feed_word(32'h40, "mid_reset", ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reset_req: got mem_req=%b want 1", bus.mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        model_core = 1'b1;
        reads_pending = 0;
        writes_pending = 0;
        checks++;
        if (bus.mem_req !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_drop: got req=%b core=%b want 0 1", bus.mem_req, core_reset);
        end
        reset = 1'b0;
        inject_ack = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || writes_pending !== 0) begin
            errors++;
            $display("FAIL late_ack: got req=%b writes=%0d want 0 0", bus.mem_req, writes_pending);
        end
        mem_auto = 1'b1;
        run_cmd("after_reset", 32'h52, 32'h40, 32'h0, 1'b0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

    initial begin
        bus.uart_response = 1'b0;
        bus.uart_read_data = '0;
        test_reset();
        test_ping();
        test_write_mem();
        test_read_mem();
        test_core_rst_error();
        test_arg_wait();
        test_random();
        test_back_to_back();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
